// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage with PC register and IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d,
    output logic                  valid_d,
    output logic                  halted,
    output logic [31:0]           fetch_count
);

    localparam logic [0:0]            S_RUN    = 1'b0;
    localparam logic [0:0]            S_HALTED = 1'b1;
    localparam logic [DATA_WIDTH-1:0] C_EBREAK = DATA_WIDTH'(32'h0010_0073);
    localparam logic [DATA_WIDTH-1:0] C_FOUR   = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] C_ALIGN  = ~DATA_WIDTH'(3);

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic [DATA_WIDTH-1:0] r_pc4_d;
    logic                  r_valid;
    logic [31:0]           r_fcount;

    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_redirect_pc;
    logic                  w_run;
    logic                  w_load;
    logic                  w_halt_load;

    assign w_pc_plus4    = r_pc + C_FOUR;
    assign w_redirect_pc = redirect_target & C_ALIGN;
    assign w_run         = (r_state == S_RUN);
    assign w_load        = w_run && !flush && !redirect && !stall;
    // An issued EBREAK parks the PC on itself so the halt address stays visible.
    assign w_halt_load   = w_load && (imem_instr == C_EBREAK);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (w_halt_load) w_state_nxt = S_HALTED;
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    // State-derived outputs
    always_comb begin
        halted = 1'b0;
        if (r_state == S_HALTED) begin
            halted = 1'b1;
        end
    end

    // PC and IF/ID datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_pc_d   <= '0;
            r_pc4_d  <= '0;
            r_valid  <= 1'b0;
            r_fcount <= '0;
        end else if (w_run) begin
            if (redirect) begin
                r_pc <= w_redirect_pc;
            end else if (!stall && !w_halt_load) begin
                r_pc <= w_pc_plus4;
            end

            if (flush || redirect) begin
                r_valid <= 1'b0;
            end else if (!stall) begin
                r_instr <= imem_instr;
                r_pc_d  <= r_pc;
                r_pc4_d <= w_pc_plus4;
                r_valid <= 1'b1;
            end

            if (w_load && (r_fcount != 32'hFFFF_FFFF)) begin
                r_fcount <= r_fcount + 32'd1;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign imem_addr   = r_pc;
    assign instr_d     = r_instr;
    assign pc_d        = r_pc_d;
    assign pc_plus4_d  = r_pc4_d;
    assign valid_d     = r_valid;
    assign fetch_count = r_fcount;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_instr, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, halted;
    logic [31:0] fetch_count;
    logic [31:0] w_imem_addr, w_imem_instr, w_instr_d, w_pc_d, w_pc_plus4_d;
    logic        w_valid_d, w_halted;
    logic [31:0] w_fetch_count;

    logic [31:0] mem [0:63];
    int total;
    int bad;

    assign imem_instr   = mem[imem_addr[7:2]];
    assign w_imem_instr = mem[w_imem_addr[7:2]];

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .halted(halted), .fetch_count(fetch_count)
    );

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_target(redirect_target), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
        .instr_d(w_instr_d), .pc_d(w_pc_d), .pc_plus4_d(w_pc_plus4_d), .valid_d(w_valid_d),
        .halted(w_halted), .fetch_count(w_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_target = '0;
        tick();
        tick();
        rst = 1'b0;
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h0); end
        total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_d); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
        total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL rst_count got=%h exp=0", fetch_count); end
        total++; if ({instr_d, pc_d, pc_plus4_d} !== 96'h0) begin bad++; $display("FAIL rst_ifid got=%h/%h/%h exp=0", instr_d, pc_d, pc_plus4_d); end
        total++; if (w_imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_wrap_addr got=%h exp=fffffffc", w_imem_addr); end
    endtask

    task automatic test_sequential();
        tick();
        total++; if ({pc_d, instr_d, valid_d} !== {32'h0, 32'h13, 1'b1}) begin bad++; $display("FAIL seq1 got pc=%h ins=%h v=%b exp pc=0 ins=13 v=1", pc_d, instr_d, valid_d); end
        total++; if (pc_plus4_d !== 32'h4) begin bad++; $display("FAIL seq1_pc4 got=%h exp=4", pc_plus4_d); end
        total++; if (w_pc_d !== 32'hFFFF_FFFC || w_instr_d !== 32'h1F93) begin bad++; $display("FAIL wrap1 got pc=%h ins=%h exp pc=fffffffc ins=1f93", w_pc_d, w_instr_d); end
        tick();
        total++; if ({pc_d, instr_d, valid_d} !== {32'h4, 32'h93, 1'b1}) begin bad++; $display("FAIL seq2 got pc=%h ins=%h v=%b exp pc=4 ins=93 v=1", pc_d, instr_d, valid_d); end
        total++; if (w_pc_d !== 32'h0 || w_instr_d !== 32'h13 || w_pc_plus4_d !== 32'h4) begin bad++; $display("FAIL wrap2 got pc=%h ins=%h p4=%h exp pc=0 ins=13 p4=4", w_pc_d, w_instr_d, w_pc_plus4_d); end
        tick();
        total++; if ({pc_d, instr_d, valid_d} !== {32'h8, 32'h113, 1'b1}) begin bad++; $display("FAIL seq3 got pc=%h ins=%h v=%b exp pc=8 ins=113 v=1", pc_d, instr_d, valid_d); end
        total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL seq_count got=%0d exp=3", fetch_count); end
        total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL seq_addr got=%h exp=c", imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL stall_addr got=%h exp=c", imem_addr); end
            total++; if ({pc_d, instr_d, valid_d} !== {32'h8, 32'h113, 1'b1}) begin bad++; $display("FAIL stall_hold got pc=%h ins=%h v=%b exp pc=8 ins=113 v=1", pc_d, instr_d, valid_d); end
            total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL stall_count got=%0d exp=3", fetch_count); end
        end
        stall = 1'b0;
        tick();
        total++; if ({pc_d, instr_d, valid_d} !== {32'hC, 32'h193, 1'b1}) begin bad++; $display("FAIL stall_release got pc=%h ins=%h v=%b exp pc=c ins=193 v=1", pc_d, instr_d, valid_d); end
        total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL stall_rel_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_target = 32'h43;
        tick();
        redirect = 1'b0;
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h exp=40", imem_addr); end
        total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", valid_d); end
        tick();
        total++; if ({pc_d, instr_d, valid_d} !== {32'h40, 32'h813, 1'b1}) begin bad++; $display("FAIL redir_load got pc=%h ins=%h v=%b exp pc=40 ins=813 v=1", pc_d, instr_d, valid_d); end
        total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL redir_count got=%0d exp=5", fetch_count); end
        redirect = 1'b1; stall = 1'b1; redirect_target = 32'h20;
        tick();
        redirect = 1'b0; stall = 1'b0;
        total++; if (imem_addr !== 32'h20 || valid_d !== 1'b0) begin bad++; $display("FAIL redir_stall got addr=%h v=%b exp addr=20 v=0", imem_addr, valid_d); end
        tick();
        total++; if ({pc_d, instr_d, fetch_count} !== {32'h20, 32'h413, 32'd6}) begin bad++; $display("FAIL redir_stall_load got pc=%h ins=%h cnt=%0d exp pc=20 ins=413 cnt=6", pc_d, instr_d, fetch_count); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if ({imem_addr, pc_d, valid_d} !== {32'h28, 32'h20, 1'b0}) begin bad++; $display("FAIL flush got addr=%h pc=%h v=%b exp addr=28 pc=20 v=0", imem_addr, pc_d, valid_d); end
        tick();
        total++; if ({pc_d, instr_d, valid_d} !== {32'h28, 32'h513, 1'b1}) begin bad++; $display("FAIL flush_next got pc=%h ins=%h v=%b exp pc=28 ins=513 v=1", pc_d, instr_d, valid_d); end
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        total++; if ({imem_addr, valid_d, fetch_count} !== {32'h2C, 1'b0, 32'd7}) begin bad++; $display("FAIL flush_stall got addr=%h v=%b cnt=%0d exp addr=2c v=0 cnt=7", imem_addr, valid_d, fetch_count); end
        tick();
        total++; if ({pc_d, instr_d, fetch_count} !== {32'h2C, 32'h593, 32'd8}) begin bad++; $display("FAIL flush_stall_next got pc=%h ins=%h cnt=%0d exp pc=2c ins=593 cnt=8", pc_d, instr_d, fetch_count); end
    endtask

    task automatic test_halt();
        mem[3] = 32'h0010_0073;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++; if ({pc_d, instr_d, valid_d, halted} !== {32'hC, 32'h0010_0073, 1'b1, 1'b1}) begin bad++; $display("FAIL halt_load got pc=%h ins=%h v=%b h=%b exp pc=c ins=00100073 v=1 h=1", pc_d, instr_d, valid_d, halted); end
        total++; if (imem_addr !== 32'hC || fetch_count !== 32'd4) begin bad++; $display("FAIL halt_pc got addr=%h cnt=%0d exp addr=c cnt=4", imem_addr, fetch_count); end
        redirect = 1'b1; redirect_target = 32'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if ({imem_addr, valid_d, halted, fetch_count} !== {32'hC, 1'b0, 1'b1, 32'd4}) begin bad++; $display("FAIL halt_hold got addr=%h v=%b h=%b cnt=%0d exp addr=c v=0 h=1 cnt=4", imem_addr, valid_d, halted, fetch_count); end
        end
        redirect = 1'b0;
    endtask

    task automatic test_reset_halted();
        rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_target = 32'h80;
        tick();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        total++; if ({halted, imem_addr, fetch_count, valid_d} !== {1'b0, 32'h0, 32'd0, 1'b0}) begin bad++; $display("FAIL rst_halt got h=%b addr=%h cnt=%0d v=%b exp h=0 addr=0 cnt=0 v=0", halted, imem_addr, fetch_count, valid_d); end
        total++; if (w_imem_addr !== 32'hFFFF_FFFC || w_halted !== 1'b0) begin bad++; $display("FAIL rst_halt_wrap got addr=%h h=%b exp addr=fffffffc h=0", w_imem_addr, w_halted); end
        tick();
        total++; if ({pc_d, instr_d, valid_d, fetch_count} !== {32'h0, 32'h13, 1'b1, 32'd1}) begin bad++; $display("FAIL rst_halt_run got pc=%h ins=%h v=%b cnt=%0d exp pc=0 ins=13 v=1 cnt=1", pc_d, instr_d, valid_d, fetch_count); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) mem[i] = (32'(i) << 7) | 32'h13;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush();
        test_halt();
        test_reset_halted();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
